// File: rtl/pir_alarm_sequencer_if.sv
// Sensor-to-alarm bus for pir_alarm_sequencer.
// master: drives arm, stop_alarm and the three raw PIR inputs; observes alarm/zone reporting.
// slave : the sequencer; samples the inputs and drives alarm_out, zone_valid, zone_id,
//         armed and event_count.
interface pir_alarm_sequencer_if;
    logic       arm;
    logic       stop_alarm;
    logic       pir_sensor_1;
    logic       pir_sensor_2;
    logic       pir_sensor_3;
    logic       alarm_out;
    logic       zone_valid;
    logic [1:0] zone_id;
    logic       armed;
    logic [7:0] event_count;

    modport master (
        output arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
        input  alarm_out, zone_valid, zone_id, armed, event_count
    );

    modport slave (
        input  arm, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
        output alarm_out, zone_valid, zone_id, armed, event_count
    );
endinterface

// File: rtl/pir_alarm_sequencer.sv
// PIR alarm sequencer: synchronises and debounces three PIR sensors, queues detections per
// zone, round-robin arbitrates them onto a single zone report, and sequences the alarm
// lifecycle DISARMED -> EXIT_DELAY -> ARMED -> ALARM -> COOLDOWN -> ARMED.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - pir_alarm_sequencer_if.slave (arm, stop_alarm, pir_sensor_1..3 in;
//           alarm_out, zone_valid, zone_id, armed, event_count out; all outputs registered)
// Optional feature: define ALARM_LATCH_EN to latch ALARM until stop_alarm or disarm
// (the alarm timeout counter is then not built).
module pir_alarm_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned ARM_DELAY       = 16,
    parameter int unsigned ALARM_TIMEOUT   = 256,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pir_alarm_sequencer_if.slave  bus
);

    localparam int unsigned NZ     = 3;
    localparam int unsigned DB_W   = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_W   = 16;
    localparam int unsigned SYNC_W = NZ + 2;
    localparam logic [CNT_W-1:0] EVT_MAX = '1;

    typedef enum logic [2:0] {
        S_DISARMED,
        S_EXIT_DELAY,
        S_ARMED,
        S_ALARM,
        S_COOLDOWN
    } state_t;

    state_t              state;
    logic [SYNC_W-1:0]   sync_q1;
    logic [SYNC_W-1:0]   sync_q2;
    logic [NZ-1:0]       sens_s;
    logic                stop_s;
    logic                arm_s;
    logic [DB_W-1:0]     db_cnt [NZ];
    logic [NZ-1:0]       pending;
    logic [1:0]          ptr;          // zone index (0..2) with highest priority
    logic [CNT_W-1:0]    dly_cnt;      // shared by exit delay and cooldown
    logic [NZ-1:0]       hit_c;
    logic [NZ-1:0]       gnt_c;
    logic [1:0]          gnt_zone_c;
    logic [1:0]          gnt_ptr_c;
    logic                timeout_c;
    logic                leave_alarm_c;
    logic                capture_en_c;
    logic                grant_en_c;
`ifndef ALARM_LATCH_EN
    logic [TO_W-1:0]     to_cnt;
`endif

    // Bit map of the synchroniser: [2:0] sensors 3..1, [3] stop_alarm, [4] arm.
    assign sens_s = sync_q2[NZ-1:0];
    assign stop_s = sync_q2[NZ];
    assign arm_s  = sync_q2[NZ+1];

    // First requesting zone at or after ptr, as a one-hot grant.
    function automatic logic [NZ-1:0] rr_pick(input logic [NZ-1:0] req, input logic [1:0] start);
        logic [NZ-1:0] gnt;
        logic [1:0]    z;
        gnt = '0;
        // Walk from furthest to nearest so the nearest requester is written last.
        for (int k = NZ - 1; k >= 0; k--) begin
            z = 2'((32'(start) + 32'(k)) % NZ);
            if (req[z]) begin
                gnt    = '0;
                gnt[z] = 1'b1;
            end
        end
        return gnt;
    endfunction

    // Debounce threshold crossing: fires once per sustained high level.
    always_comb begin
        hit_c = '0;
        for (int z = 0; z < NZ; z++) begin
            hit_c[z] = sens_s[z] && (db_cnt[z] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

`ifdef ALARM_LATCH_EN
    assign timeout_c = 1'b0;
`else
    assign timeout_c = (to_cnt == TO_W'(1));
`endif

    // Leaving ALARM (stop or timeout) and disarm both suppress the grant in that cycle.
    assign leave_alarm_c = (state == S_ALARM) && (stop_s || timeout_c);
    assign capture_en_c  = (state == S_ARMED) || (state == S_ALARM);
    assign grant_en_c    = capture_en_c && arm_s && !leave_alarm_c;
    assign gnt_c         = grant_en_c ? rr_pick(pending, ptr) : '0;

    // Granted zone number (1..3) and the pointer that follows it.
    always_comb begin
        gnt_zone_c = 2'd1;
        gnt_ptr_c  = 2'd1;
        if (gnt_c[1]) begin
            gnt_zone_c = 2'd2;
            gnt_ptr_c  = 2'd2;
        end else if (gnt_c[2]) begin
            gnt_zone_c = 2'd3;
            gnt_ptr_c  = 2'd0;
        end
    end

    // Synchronisers, debounce, pending queue, arbitration and lifecycle FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_DISARMED;
            sync_q1         <= '0;
            sync_q2         <= '0;
            for (int z = 0; z < NZ; z++) begin
                db_cnt[z] <= '0;
            end
            pending         <= '0;
            ptr             <= '0;
            dly_cnt         <= '0;
`ifndef ALARM_LATCH_EN
            to_cnt          <= '0;
`endif
            bus.alarm_out   <= 1'b0;
            bus.zone_valid  <= 1'b0;
            bus.zone_id     <= '0;
            bus.armed       <= 1'b0;
            bus.event_count <= '0;
        end else begin
            sync_q1 <= {bus.arm, bus.stop_alarm, bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1};
            sync_q2 <= sync_q1;

            for (int z = 0; z < NZ; z++) begin
                if (!sens_s[z]) begin
                    db_cnt[z] <= '0;
                end else if (db_cnt[z] != DB_W'(DEBOUNCE_CYCLES)) begin
                    db_cnt[z] <= db_cnt[z] + DB_W'(1);
                end
            end

            // A zone granted and re-hit in the same cycle stays pending.
            pending        <= (pending & ~gnt_c) | (hit_c & {NZ{capture_en_c}});
            bus.zone_valid <= |gnt_c;
            if (|gnt_c) begin
                bus.zone_id <= gnt_zone_c;
                ptr         <= gnt_ptr_c;
                if (bus.event_count != EVT_MAX) begin
                    bus.event_count <= bus.event_count + CNT_W'(1);
                end
            end

            case (state)
                S_DISARMED: begin
                    if (arm_s) begin
                        state           <= S_EXIT_DELAY;
                        dly_cnt         <= CNT_W'(ARM_DELAY);
                        bus.event_count <= '0;
                        bus.zone_id     <= '0;
                    end
                end
                S_EXIT_DELAY: begin
                    if (dly_cnt == CNT_W'(1)) begin
                        state     <= S_ARMED;
                        bus.armed <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    // Registered grant pulse starts the alarm one cycle after zone_valid.
                    if (bus.zone_valid) begin
                        state         <= S_ALARM;
                        bus.alarm_out <= 1'b1;
`ifndef ALARM_LATCH_EN
                        to_cnt        <= TO_W'(ALARM_TIMEOUT);
`endif
                    end
                end
                S_ALARM: begin
                    if (leave_alarm_c) begin
                        state         <= S_COOLDOWN;
                        dly_cnt       <= CNT_W'(COOLDOWN_CYCLES);
                        pending       <= '0;
                        bus.alarm_out <= 1'b0;
                    end
`ifndef ALARM_LATCH_EN
                    else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
`endif
                end
                S_COOLDOWN: begin
                    if (dly_cnt == CNT_W'(1)) begin
                        state <= S_ARMED;
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end
                default: state <= S_DISARMED;
            endcase

            // Disarm overrides everything else; zone_id and event_count are kept.
            if (!arm_s) begin
                state         <= S_DISARMED;
                pending       <= '0;
                bus.alarm_out <= 1'b0;
                bus.armed     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pir_alarm_sequencer.sv
// Directed bench for pir_alarm_sequencer with a grant scoreboard.
module tb_pir_alarm_sequencer;

    typedef struct packed {
        logic [1:0] zone;
        logic [7:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    pir_alarm_sequencer_if bus ();

    pir_alarm_sequencer #(
        .DEBOUNCE_CYCLES (2),
        .ARM_DELAY       (16),
        .ALARM_TIMEOUT   (20),
        .COOLDOWN_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input logic [1:0] zone, input logic [7:0] count);
        exp_t e;
        e.zone  = zone;
        e.count = count;
        exp_q.push_back(e);
    endtask

    // Advance n clocks, sampling 1 time unit after each edge; every grant is scored.
    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.zone_valid === 1'b1) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_grant observed zone_id=%0d expected no grant", bus.zone_id);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    assert (bus.zone_id === e.zone && bus.event_count === e.count) else begin
                        fails++;
                        $error("FAIL grant observed zone_id=%0d event_count=%0d expected zone_id=%0d event_count=%0d",
                               bus.zone_id, bus.event_count, e.zone, e.count);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.arm          = 1'b0;
        bus.stop_alarm   = 1'b0;
        bus.pir_sensor_1 = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;

        // Reset
        tick(2);
        chk("rst_alarm_out",   32'(bus.alarm_out),   0);
        chk("rst_zone_valid",  32'(bus.zone_valid),  0);
        chk("rst_zone_id",     32'(bus.zone_id),     0);
        chk("rst_armed",       32'(bus.armed),       0);
        chk("rst_event_count", 32'(bus.event_count), 0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_armed", 32'(bus.armed), 0);

        // Arm: 2 sync + 1 entry + 16 exit-delay cycles
        bus.arm = 1'b1;
        tick(18);
        chk("exit_delay_armed", 32'(bus.armed), 0);
        tick(1);
        chk("armed_rise",      32'(bus.armed),       1);
        chk("armed_alarm_out", 32'(bus.alarm_out),   0);
        chk("armed_zone_id",   32'(bus.zone_id),     0);
        chk("armed_events",    32'(bus.event_count), 0);

        // One-cycle glitch on zone 2 must not be detected
        bus.pir_sensor_2 = 1'b1;
        tick(1);
        bus.pir_sensor_2 = 1'b0;
        tick(10);
        chk("glitch_events", 32'(bus.event_count), 0);

        // Single detection on zone 1
        expect_grant(2'd1, 8'd1);
        bus.pir_sensor_1 = 1'b1;
        tick(3);
        bus.pir_sensor_1 = 1'b0;
        tick(1);
        chk("det_not_yet", 32'(bus.zone_valid), 0);
        tick(1);
        chk("det_alarm_lag", 32'(bus.alarm_out), 0);
        tick(1);
        chk("det_alarm_on",  32'(bus.alarm_out), 1);
        chk("det_drained",   32'(exp_q.size()),  0);

        // Round robin: pointer sits after zone 1, so order is 2,3,1
        expect_grant(2'd2, 8'd2);
        expect_grant(2'd3, 8'd3);
        expect_grant(2'd1, 8'd4);
        bus.pir_sensor_1 = 1'b1;
        bus.pir_sensor_2 = 1'b1;
        bus.pir_sensor_3 = 1'b1;
        tick(8);
        chk("rr_drained", 32'(exp_q.size()),    0);
        chk("rr_events",  32'(bus.event_count), 4);
        chk("rr_alarm",   32'(bus.alarm_out),   1);

        // Stop pulse -> COOLDOWN
        bus.pir_sensor_1 = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;
        bus.stop_alarm   = 1'b1;
        tick(1);
        bus.stop_alarm   = 1'b0;
        tick(1);
        chk("stop_alarm_held", 32'(bus.alarm_out), 1);
        tick(1);
        chk("stop_alarm_off",  32'(bus.alarm_out), 0);
        chk("stop_armed",      32'(bus.armed),     1);

        // Detection during cooldown is ignored; armed stays high
        bus.pir_sensor_3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("cool_armed", 32'(bus.armed), 1);
        end
        bus.pir_sensor_3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("cool_armed", 32'(bus.armed), 1);
        end
        chk("cool_events", 32'(bus.event_count), 4);

        // Back in ARMED: new alarm from zone 2, then timeout or latch
        expect_grant(2'd2, 8'd5);
        bus.pir_sensor_2 = 1'b1;
        tick(3);
        bus.pir_sensor_2 = 1'b0;
        tick(3);
        chk("to_alarm_on", 32'(bus.alarm_out), 1);
`ifdef ALARM_LATCH_EN
        tick(100);
        chk("latch_held", 32'(bus.alarm_out), 1);
        bus.stop_alarm = 1'b1;
        tick(1);
        bus.stop_alarm = 1'b0;
        tick(2);
        chk("latch_stopped", 32'(bus.alarm_out), 0);
`else
        tick(19);
        chk("to_alarm_last", 32'(bus.alarm_out), 1);
        tick(1);
        chk("to_alarm_off",  32'(bus.alarm_out), 0);
`endif
        chk("to_armed", 32'(bus.armed), 1);
        tick(12);

        // Disarm beats stop_alarm and pending grants
        expect_grant(2'd1, 8'd6);
        bus.pir_sensor_1 = 1'b1;
        tick(3);
        bus.pir_sensor_1 = 1'b0;
        tick(3);
        chk("dis_alarm_on", 32'(bus.alarm_out), 1);
        bus.pir_sensor_2 = 1'b1;
        bus.pir_sensor_3 = 1'b1;
        tick(2);
        bus.arm        = 1'b0;
        bus.stop_alarm = 1'b1;
        tick(3);
        chk("dis_alarm_off",  32'(bus.alarm_out),   0);
        chk("dis_armed",      32'(bus.armed),       0);
        chk("dis_zone_valid", 32'(bus.zone_valid),  0);
        chk("dis_events",     32'(bus.event_count), 6);
        chk("dis_zone_id",    32'(bus.zone_id),     1);
        bus.stop_alarm   = 1'b0;
        bus.pir_sensor_2 = 1'b0;
        bus.pir_sensor_3 = 1'b0;
        tick(5);
        chk("dis_stays_off", 32'(bus.armed), 0);

        // Reset mid-operation clears the counters
        rst_n = 1'b0;
        tick(1);
        chk("rst2_events",  32'(bus.event_count), 0);
        chk("rst2_zone_id", 32'(bus.zone_id),     0);
        rst_n = 1'b1;

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
